// File: rtl/imem_loader.sv
// imem_loader: byte-stream to instruction memory writer holding the CPU in reset; optional checksum via IMEM_LOADER_CHECKSUM_EN
module imem_loader #(
  parameter int DEPTH = 64,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);
`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {LEN0, LEN1, DATA, FIN, DONE, ERR, CSUM} state_t;
  localparam state_t POST = CSUM;
  logic [7:0] csum;
`else
  typedef enum logic [2:0] {LEN0, LEN1, DATA, FIN, DONE, ERR} state_t;
  localparam state_t POST = FIN;
`endif
  state_t state, nxt;
  logic [CNT_W-1:0] len, widx, hdr;
  logic [1:0] bcnt;
  logic [23:0] sbuf;
  logic acc, words_done;
  assign hdr = CNT_W'({in_data, len[7:0]});
  assign words_done = widx == len;
  assign acc = in_valid && in_ready;
  assign done = state == DONE;
  assign error = state == ERR;
  assign cpu_hold = state != DONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign in_ready = state == LEN0 || state == LEN1 || state == CSUM || (state == DATA && !words_done);
`else
  assign in_ready = state == LEN0 || state == LEN1 || (state == DATA && !words_done);
`endif
  always_comb begin
    nxt = state;
    case (state)
      LEN0: nxt = acc ? LEN1 : LEN0;
      LEN1: nxt = !acc ? LEN1 : hdr == '0 ? POST : hdr > CNT_W'(DEPTH) ? ERR : DATA;
      DATA: nxt = words_done ? POST : DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: nxt = !acc ? CSUM : in_data == csum ? FIN : ERR;
`endif
      FIN: nxt = DONE;
      DONE, ERR: nxt = start ? LEN0 : state;
      default: nxt = LEN0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LEN0;
      len <= '0;
      widx <= '0;
      bcnt <= '0;
      sbuf <= '0;
      mem_we <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum <= '0;
`endif
    end else begin
      state <= nxt;
      mem_we <= 1'b0;
      if (state == LEN0 && acc)
        len[7:0] <= in_data;
      if (state == LEN1 && acc) begin
        len <= hdr;
        widx <= '0;
        bcnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum <= '0;
`endif
      end
      if (state == DATA && acc) begin
        bcnt <= bcnt + 2'd1;
        sbuf <= {in_data, sbuf[23:8]};
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum <= csum ^ in_data;
`endif
        if (bcnt == 2'd3) begin
          mem_we <= 1'b1;
          mem_waddr <= 32'({widx, 2'b00});
          mem_wdata <= {in_data, sbuf};
          widx <= widx + CNT_W'(1);
        end
      end
      if ((state == DONE || state == ERR) && start) begin
        widx <= '0;
        bcnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and randomized image loads checked against a word-list memory model
module tb_imem_loader;
  localparam int DEPTH = 64;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    int c;
  } wr_t;
  logic clk = 0, reset = 1, start = 0, in_valid = 0;
  logic [7:0] in_data = 0;
  logic in_ready, mem_we, cpu_hold, done, error;
  logic [31:0] mem_waddr, mem_wdata;
  int checks = 0, errors = 0;
  int cyc = 0, dbl = 0, done_cyc = 0;
  bit done_seen = 0, we_prev = 0;
  wr_t wq[$];
  logic [31:0] img [DEPTH];
  logic [31:0] dut_mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic [7:0] cs_flip = 0;
  imem_loader #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    cyc++;
    if (mem_we) begin
      wq.push_back('{mem_waddr, mem_wdata, cyc});
      if (mem_waddr[31:2] < DEPTH)
        dut_mem[mem_waddr[7:2]] = mem_wdata;
    end
    if (mem_we && we_prev)
      dbl++;
    we_prev = mem_we;
    if (done && !done_seen) begin
      done_seen = 1;
      done_cyc = cyc;
    end
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b, input int mode);
    int t = 0;
    in_valid = 1;
    in_data = b;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("ready_wait", in_ready, 1);
    @(negedge clk);
    if (mode == 1 || (mode == 2 && $urandom_range(1, 0) == 1)) begin
      in_valid = 0;
      in_data = 8'($urandom);
      repeat (mode == 1 ? 1 : $urandom_range(3, 1)) @(negedge clk);
    end
  endtask
  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
    check("start_ready", in_ready, 1);
    check("start_err", error, 0);
    check("start_done", done, 0);
    check("start_hold", cpu_hold, 1);
  endtask
  task automatic load_image(input int n, input int mode, input int start_at);
    logic [7:0] cs = 0;
    logic [7:0] b;
    int k = 0, t = 0;
    wq.delete();
    done_seen = 0;
    send_byte(n[7:0], mode);
    send_byte(n[15:8], mode);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 4; j++) begin
        b = img[i][8*j +: 8];
        if (k == start_at) begin
          in_valid = 0;
          start = 1;
          @(negedge clk);
          start = 0;
        end
        send_byte(b, mode);
        cs ^= b;
        k++;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(cs ^ cs_flip, mode);
`endif
    in_valid = 0;
    while (!done && !error && t < 40) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
  endtask
  task automatic check_image(input int n);
    for (int i = 0; i < n; i++)
      ref_mem[i] = img[i];
    check("nwrites", wq.size(), n);
    for (int i = 0; i < n && i < wq.size(); i++) begin
      check("waddr", wq[i].a, 32'(i * 4));
      check("wdata", wq[i].d, img[i]);
    end
`ifndef IMEM_LOADER_CHECKSUM_EN
    if (n > 0 && wq.size() > 0)
      check("done_latency", done_cyc - wq[wq.size()-1].c, 2);
`endif
    check("done", done, 1);
    check("hold_low", cpu_hold, 0);
    check("ready_low", in_ready, 0);
    check("no_error", error, 0);
    check("we_double", dbl, 0);
    for (int i = 0; i < DEPTH; i++)
      check("mem_word", dut_mem[i], ref_mem[i]);
  endtask
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      dut_mem[i] = 0;
      ref_mem[i] = 0;
    end
    repeat (3) @(negedge clk);
    check("rst_ready", in_ready, 1);
    check("rst_we", mem_we, 0);
    check("rst_waddr", mem_waddr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_hold", cpu_hold, 1);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    reset = 0;
    @(negedge clk);
    img[0] = 32'h0000_0013;
    img[1] = 32'h0050_0293;
    load_image(2, 0, -1);
    check_image(2);
    pulse_start();
    load_image(2, 1, 3);
    check_image(2);
    pulse_start();
    wq.delete();
    send_byte(8'h41, 0);
    send_byte(8'h00, 0);
    check("hdr_err", error, 1);
    check("hdr_ready", in_ready, 0);
    check("hdr_hold", cpu_hold, 1);
    in_data = 8'hAA;
    repeat (3) @(negedge clk);
    in_valid = 0;
    check("hdr_nowr", wq.size(), 0);
    check("hdr_err_hold", error, 1);
    pulse_start();
    load_image(0, 0, -1);
    check_image(0);
    pulse_start();
    wq.delete();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    in_valid = 0;
    reset = 1;
    @(negedge clk);
    reset = 0;
    repeat (5) @(negedge clk);
    check("rst_mid_nowr", wq.size(), 0);
    check("rst_mid_ready", in_ready, 1);
    check("rst_mid_hold", cpu_hold, 1);
    img[0] = 32'h0000_0073;
    load_image(1, 0, -1);
    check_image(1);
    for (int r = 0; r < 6; r++) begin
      int n;
      n = r == 0 ? DEPTH : r == 1 ? 1 : $urandom_range(DEPTH - 1, 2);
      for (int i = 0; i < n; i++)
        img[i] = $urandom;
      pulse_start();
      load_image(n, 2, r == 2 ? 5 : -1);
      check_image(n);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    img[0] = 32'h0000_0013;
    pulse_start();
    load_image(1, 0, -1);
    check_image(1);
    pulse_start();
    cs_flip = 8'h01;
    load_image(1, 0, -1);
    cs_flip = 8'h00;
    check("cs_err", error, 1);
    check("cs_hold", cpu_hold, 1);
    check("cs_done", done, 0);
    check("cs_wr", wq.size(), 1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
